// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter merging I-cache and D-cache block
// requests onto a single registered L2/memory port.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t r_state;
  logic   r_last_d;
  logic   r_fresh;

  logic              w_i_pend;
  logic              w_d_pend;
  logic              w_grant_d;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // The last owner may still hold its request in the first idle
  // cycle after its ready pulse; that request is not a new one.
  assign w_i_pend  = (i_read | i_write) & ~(r_fresh & ~r_last_d);
  assign w_d_pend  = (d_read | d_write) & ~(r_fresh & r_last_d);
  assign w_grant_d = w_d_pend & (~w_i_pend | ~r_last_d);
  assign w_wr      = w_grant_d ? d_write : i_write;
  assign w_addr    = w_grant_d ? d_addr  : i_addr;
  assign w_wdata   = w_grant_d ? d_wdata : i_wdata;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_fresh   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_fresh <= 1'b0;
          if (w_i_pend | w_d_pend) begin
            r_last_d  <= w_grant_d;
            mem_write <= w_wr;
            mem_read  <= ~w_wr;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
              if (r_last_d) d_rdata <= mem_rdata;
              else          i_rdata <= mem_rdata;
            end
            if (r_last_d) d_ready <= 1'b1;
            else          i_ready <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          r_fresh <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal values, random traffic.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight at most, a one-cycle
  // completion pulse, then the completing client's held request is
  // disregarded for one more cycle.
  logic          m_busy, m_wr, m_last_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd_i, m_rd_d;
  logic          m_rdy_i, m_rdy_d, m_ign_i, m_ign_d;
  logic          mp_i, mp_d, m_gd;

  assign mp_i = (i_read | i_write) & ~m_ign_i;
  assign mp_d = (d_read | d_write) & ~m_ign_d;
  assign m_gd = mp_d & (~mp_i | ~m_last_d);

  always @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      m_busy <= 1'b0; m_wr <= 1'b0; m_last_d <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_rd_i <= '0; m_rd_d <= '0;
      m_rdy_i <= 1'b0; m_rdy_d <= 1'b0;
      m_ign_i <= 1'b0; m_ign_d <= 1'b0;
    end else if (m_rdy_i || m_rdy_d) begin
      m_ign_i <= m_rdy_i;
      m_ign_d <= m_rdy_d;
      m_rdy_i <= 1'b0;
      m_rdy_d <= 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy <= 1'b0;
        if (!m_wr && m_last_d)  m_rd_d <= mem_rdata;
        if (!m_wr && !m_last_d) m_rd_i <= mem_rdata;
        if (m_last_d) m_rdy_d <= 1'b1;
        else          m_rdy_i <= 1'b1;
      end
    end else begin
      m_ign_i <= 1'b0;
      m_ign_d <= 1'b0;
      if (mp_i || mp_d) begin
        m_busy   <= 1'b1;
        m_last_d <= m_gd;
        m_wr     <= m_gd ? d_write : i_write;
        m_addr   <= m_gd ? d_addr  : i_addr;
        m_wdata  <= m_gd ? d_wdata : i_wdata;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_read"},  DW'(mem_read),  '0);
    chk({pfx, "_mem_write"}, DW'(mem_write), '0);
    chk({pfx, "_mem_addr"},  DW'(mem_addr),  '0);
    chk({pfx, "_mem_wdata"}, mem_wdata,      '0);
    chk({pfx, "_i_rdata"},   i_rdata,        '0);
    chk({pfx, "_d_rdata"},   d_rdata,        '0);
    chk({pfx, "_i_ready"},   DW'(i_ready),   '0);
    chk({pfx, "_d_ready"},   DW'(d_ready),   '0);
  endtask

  logic ia = 0, il = 0, da = 0, dl = 0;

  task automatic rand_run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (ia) begin
        if (i_ready) begin
          ia = 0;
          if ($urandom_range(0, 1) == 1) il = 1;
          else begin i_read = 0; i_write = 0; end
        end
      end else if (il) begin
        il = 0; i_read = 0; i_write = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        ia = 1;
        i_read  = 1'b1;
        i_write = ($urandom_range(0, 5) == 0);
        i_addr  = AW'($urandom);
        i_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (da) begin
        if (d_ready) begin
          da = 0;
          if ($urandom_range(0, 1) == 1) dl = 1;
          else begin d_read = 0; d_write = 0; end
        end
      end else if (dl) begin
        dl = 0; d_read = 0; d_write = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        da = 1;
        d_read  = (op != 1);
        d_write = (op != 0);
        d_addr  = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  logic [DW-1:0] a5, x11, x5a;
  logic [AW-1:0] order[$];
  int            got;
  logic          prev;

  initial begin
    a5  = {4{32'hA5A5A5A5}};
    x11 = {4{32'h11111111}};
    x5a = {4{32'h5A5A5A5A}};
    proc_reset = 1'b1;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 0;

    fork
      forever begin
        @(negedge clk);
        chk("mem_read",  DW'(mem_read),  DW'(m_busy & ~m_wr));
        chk("mem_write", DW'(mem_write), DW'(m_busy & m_wr));
        chk("mem_addr",  DW'(mem_addr),  DW'(m_addr));
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("i_ready",   DW'(i_ready),   DW'(m_rdy_i));
        chk("d_ready",   DW'(d_ready),   DW'(m_rdy_d));
        chk("i_rdata",   i_rdata,        m_rd_i);
        chk("d_rdata",   d_rdata,        m_rd_d);
      end
    join_none

    idle(3);
    chk_zero("reset");
    proc_reset = 1'b0;
    idle(1);

    // I read, memory answers on the third busy cycle; I-cache holds
    // its request through the ready pulse and one cycle after.
    i_read = 1; i_addr = 28'h0000010;
    idle(1);
    chk("A_mem_read_c1", DW'(mem_read), 1);
    chk("A_mem_addr",    DW'(mem_addr), DW'(28'h10));
    idle(1);
    chk("A_mem_read_c2", DW'(mem_read), 1);
    idle(1);
    chk("A_mem_read_c3", DW'(mem_read), 1);
    mem_ready = 1; mem_rdata = a5;
    idle(1);
    mem_ready = 0; mem_rdata = '0;
    chk("A_i_ready_c4",  DW'(i_ready),  1);
    chk("A_mem_read_c4", DW'(mem_read), 0);
    chk("A_i_rdata",     i_rdata,       a5);
    idle(1);
    chk("A_i_ready_c5",  DW'(i_ready),  0);
    idle(1);
    i_read = 0;
    chk("A_no_dup", DW'(mem_read), 0);
    idle(2);
    chk("A_no_dup2",   DW'(mem_read), 0);
    chk("A_rdata_hold", i_rdata, a5);

    // Reset while BUSY, then a stray mem_ready.
    d_read = 1; d_addr = 28'h33;
    idle(1);
    chk("F_busy", DW'(mem_read), 1);
    @(posedge clk);
    #2 proc_reset = 1'b1;
    d_read = 0;
    #1 chk_zero("F_async");
    @(negedge clk);
    proc_reset = 1'b0;
    idle(1);
    mem_ready = 1; mem_rdata = {4{32'hFFFFFFFF}};
    idle(1);
    mem_ready = 0;
    chk("F_no_dready", DW'(d_ready), 0);
    chk("F_idle",      DW'(mem_read), 0);
    idle(1);
    chk("F_no_dready2", DW'(d_ready), 0);
    chk("F_drdata",     d_rdata,      '0);

    // Tie after reset: I first, then D's write.
    i_read = 1; i_addr = 28'h1;
    d_write = 1; d_addr = 28'h2; d_wdata = x11;
    idle(1);
    chk("B_i_first", DW'(mem_read), 1);
    chk("B_addr1",   DW'(mem_addr), 1);
    mem_ready = 1; mem_rdata = x5a;
    idle(1);
    mem_ready = 0;
    chk("B_i_ready", DW'(i_ready), 1);
    chk("B_i_rdata", i_rdata,      x5a);
    idle(1);
    i_read = 0;
    idle(1);
    chk("B_d_write", DW'(mem_write), 1);
    chk("B_d_read0", DW'(mem_read),  0);
    chk("B_addr2",   DW'(mem_addr),  2);
    chk("B_wdata",   mem_wdata,      x11);
    mem_ready = 1;
    idle(1);
    mem_ready = 0;
    d_write = 0;
    chk("B_d_ready", DW'(d_ready), 1);
    chk("B_d_rdata", d_rdata,      '0);
    idle(3);

    // Read and write both high: treated as a write.
    d_read = 1; d_write = 1; d_addr = 28'h44;
    idle(1);
    chk("E_write", DW'(mem_write), 1);
    chk("E_read0", DW'(mem_read),  0);
    mem_ready = 1;
    idle(1);
    mem_ready = 0;
    d_read = 0; d_write = 0;
    chk("E_d_ready", DW'(d_ready), 1);
    idle(3);

    // Continuous contention: grants must alternate starting with I.
    i_read = 1; i_addr = 28'hA;
    d_write = 1; d_addr = 28'hB; d_wdata = {4{$urandom}};
    mem_ready = 1; mem_rdata = {4{$urandom}};
    got = 0; prev = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if ((mem_read | mem_write) && !prev) begin
        order.push_back(mem_addr);
        got++;
        if (got == 6) begin i_read = 0; d_write = 0; end
      end
      prev = mem_read | mem_write;
    end
    chk("C_grant_count", DW'(got), 6);
    foreach (order[k])
      chk("C_order", DW'(order[k]), (k % 2 == 0) ? DW'(28'hA) : DW'(28'hB));
    idle(3);
    mem_ready = 0;
    chk("C_d_rdata_kept", d_rdata, '0);
    idle(2);

    rand_run(400);
    @(posedge clk);
    #2 proc_reset = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    ia = 0; il = 0; da = 0; dl = 0;
    #1 chk_zero("R_async");
    @(negedge clk);
    proc_reset = 1'b0;
    rand_run(400);
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    mem_ready = 0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client memory arbiter between the L1 caches and the shared L2/memory port. Merges the I-cache miss-fill port (client I) and the D-cache fill/write-back port (client D) onto one 128-bit block interface. Arbitrates round-robin on ties, forwards one transaction at a time, and returns a one-cycle ready pulse plus held read data to the owning client.

## Interface
- ADDR_W, 28, block address width (word address >> 2)
- DATA_W, 128, block data width
- clk  in  1  single clock, rising edge
- proc_reset  in  1  asynchronous, active-high reset
- i_read, i_write  in  1 each  client I request (I-cache drives i_write=0)
- i_addr  in  ADDR_W  client I block address
- i_wdata  in  DATA_W  client I write data
- i_rdata  out  DATA_W  client I read data
- i_ready  out  1  client I completion pulse
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as client I, for client D
- mem_read, mem_write  out  1 each  downstream request, registered
- mem_addr  out  ADDR_W  downstream address, registered
- mem_wdata  out  DATA_W  downstream write data, registered
- mem_rdata  in  DATA_W  downstream read data, valid when mem_ready=1
- mem_ready  in  1  downstream completion, one cycle per transaction

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE.
- Reset values: all outputs 0; last_grant = D (so client I wins the first tie); internal request registers 0.
- IDLE: sample both clients. A client is pending if read|write. If read and write are both high, the request is a write.
  - None pending: stay IDLE.
  - One pending: grant it.
  - Both pending: grant the client not equal to last_grant.
  - On grant: latch owner, op, addr, wdata into mem_* registers; set last_grant = owner; go to BUSY.
- BUSY: mem_read/mem_write/mem_addr/mem_wdata stay constant. Client inputs are ignored.
  - mem_ready=0: stay BUSY, with no timeout.
  - mem_ready=1: clear mem_read/mem_write on the next edge. For a read, latch mem_rdata into the owner's rdata register. Go to DONE.
- DONE: owner's ready=1 for exactly this cycle. All client requests are ignored, because clients still hold their request during the ready cycle. Go to IDLE.
- i_rdata/d_rdata hold their value from the owner's last read completion until that client's next read completion. Writes never change rdata. The other client's rdata is never touched.
- Clients drop their request no later than the cycle after their ready pulse. A request still high in IDLE after that is treated as a new transaction.
- mem_rdata is sampled only in BUSY with mem_ready=1. mem_ready in IDLE or DONE is ignored.

## Timing
- Request sampled in IDLE at cycle 0 -> mem_read/mem_write high from cycle 1.
- mem_ready high at cycle k (k >= 1) -> mem_read/mem_write low at k+1, client ready pulse at k+1, client rdata valid from k+1.
- Minimum client latency: request at 0, ready at 2, 3 cycles per transaction including DONE.
- Back-to-back: the next grant is decided in the IDLE cycle following DONE. Throughput is at most one transaction per 3 cycles.
- Simultaneous events:
  - A new request arriving while BUSY waits; it is not lost as long as the client holds it.
  - A tie at IDLE is resolved by last_grant only. Alternating service is guaranteed under continuous contention.
- Reset mid-operation (any state): outputs go to 0 immediately and asynchronously; state -> IDLE; rdata registers cleared; last_grant = D.
  - The in-flight downstream transaction is abandoned; a later stray mem_ready is ignored.
  - No ready pulse is issued for the abandoned request.

## Test plan
- Reset check: assert proc_reset mid-clock. All outputs must go to 0 before the next edge. After release, i_read=1, i_addr=0x0000010, memory ready after 3 cycles with rdata=0xA5..A5 -> mem_read cycles 1-3, i_ready at cycle 4, i_rdata=0xA5..A5 held until the next I read.
- Simultaneous i_read (addr 0x1) and d_write (addr 0x2, wdata 0x11..11) at cycle 0 -> I served first (mem_addr=0x1), then D (mem_write=1, mem_addr=0x2, mem_wdata=0x11..11). Second tie goes to D after I wins.
- Continuous contention, 6 transactions -> grant order I,D,I,D,I,D. d_rdata unchanged across D writes.
- Client keeps i_read high during and one cycle after the i_ready pulse (I-cache behaviour) -> exactly one downstream transaction, with no duplicate.
- d_read and d_write both high -> mem_write=1, mem_read=0.
- proc_reset asserted in BUSY, then mem_ready pulses after release -> no ready pulse, state IDLE, next request served normally.
